// File: rtl/cnt_dly_array_pkg.sv
// Shared types and default sizing for the counter/delay channel array.
package cnt_dly_array_pkg;

  localparam int unsigned DEF_CH_NUM      = 4;
  localparam int unsigned DEF_CNT_WIDTH   = 14;
  localparam int unsigned DEF_PRESC_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_DLY     = 2'd0,
    MODE_CNT     = 2'd1,
    MODE_FSM     = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_BOTH    = 2'd2,
    EDGE_NONE    = 2'd3
  } edge_t;

endpackage

// File: rtl/cnt_dly_channel.sv
// One counter/delay channel: edge qualifier, prescaler and mode-dependent counter.
module cnt_dly_channel
  import cnt_dly_array_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned PRESC_WIDTH = DEF_PRESC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [1:0]             edge_sel,
  input  logic [CNT_WIDTH-1:0]   data,
  input  logic [PRESC_WIDTH-1:0] presc,
  input  logic                   use_cascade,
  input  logic                   cascade_tick,
  input  logic                   clr,
  input  logic                   din,
  input  logic                   keep,
  input  logic                   up,
  output logic                   out,
  output logic                   edge_det,
  output logic                   tc,
  output logic [CNT_WIDTH-1:0]   count
);

  logic                   in_q;
  logic                   busy;
  logic [PRESC_WIDTH-1:0] presc_cnt;

  logic                   in_n;
  logic                   busy_n;
  logic [PRESC_WIDTH-1:0] presc_n;
  logic                   out_n;
  logic                   edge_n;
  logic                   tc_n;
  logic [CNT_WIDTH-1:0]   count_n;

  logic presc_wrap_c;
  logic tick_c;
  logic qedge_c;

  // Tick source and qualified-edge decode.
  always_comb begin
    presc_wrap_c = (presc_cnt >= presc);
    tick_c       = use_cascade ? cascade_tick : presc_wrap_c;
    qedge_c      = 1'b0;
    case (edge_t'(edge_sel))
      EDGE_RISING:  qedge_c = din & ~in_q;
      EDGE_FALLING: qedge_c = ~din & in_q;
      EDGE_BOTH:    qedge_c = din ^ in_q;
      EDGE_NONE:    qedge_c = 1'b0;
    endcase
  end

  // Next-state for all channel registers; clear overrides every event.
  always_comb begin
    in_n    = din;
    presc_n = presc_wrap_c ? '0 : presc_cnt + PRESC_WIDTH'(1);
    count_n = count;
    out_n   = out;
    busy_n  = busy;
    edge_n  = qedge_c;
    tc_n    = 1'b0;
    if (clr) begin
      in_n    = 1'b0;
      presc_n = '0;
      count_n = '0;
      out_n   = 1'b0;
      busy_n  = 1'b0;
      edge_n  = 1'b0;
    end else begin
      case (mode_t'(mode))
        MODE_DLY: begin
          if (qedge_c) begin
            count_n = data;
            busy_n  = 1'b1;
          end else if (!busy) begin
            out_n = in_q;
          end else if (tick_c) begin
            if (count == '0) begin
              out_n  = in_q;
              busy_n = 1'b0;
            end else begin
              count_n = count - CNT_WIDTH'(1);
            end
          end
        end
        MODE_CNT: begin
          out_n = 1'b0;
          if (qedge_c) begin
            count_n = data;
          end else if (tick_c) begin
            if (count == '0) begin
              count_n = data;
              out_n   = 1'b1;
              tc_n    = 1'b1;
            end else begin
              count_n = count - CNT_WIDTH'(1);
            end
          end
        end
        MODE_FSM: begin
          if (qedge_c) begin
            count_n = '0;
          end else if (tick_c && !keep) begin
            if (up) begin
              if (count < data) begin
                count_n = count + CNT_WIDTH'(1);
                tc_n    = (count_n == data);
              end
            end else if (count != '0) begin
              count_n = count - CNT_WIDTH'(1);
              tc_n    = (count_n == '0);
            end
          end
          out_n = up ? (count_n == data) : (count_n == '0);
        end
        MODE_ONESHOT: begin
          if (!out) begin
            if (qedge_c) begin
              out_n   = 1'b1;
              count_n = data;
            end
          end else if (tick_c) begin
            if (count == '0) begin
              out_n = 1'b0;
              tc_n  = 1'b1;
            end else begin
              count_n = count - CNT_WIDTH'(1);
            end
          end
        end
      endcase
    end
  end

  // Channel state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q      <= 1'b0;
      busy      <= 1'b0;
      presc_cnt <= '0;
      count     <= '0;
      out       <= 1'b0;
      edge_det  <= 1'b0;
      tc        <= 1'b0;
    end else begin
      in_q      <= in_n;
      busy      <= busy_n;
      presc_cnt <= presc_n;
      count     <= count_n;
      out       <= out_n;
      edge_det  <= edge_n;
      tc        <= tc_n;
    end
  end

endmodule

// File: rtl/cnt_dly_array.sv
// Array of independent counter/delay channels with optional tick cascading.
module cnt_dly_array
  import cnt_dly_array_pkg::*;
#(
  parameter int unsigned CH_NUM      = DEF_CH_NUM,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int unsigned PRESC_WIDTH = DEF_PRESC_WIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [2*CH_NUM-1:0]           i_cfg_mode,
  input  logic [2*CH_NUM-1:0]           i_cfg_edge,
  input  logic [CNT_WIDTH*CH_NUM-1:0]   i_cfg_data,
  input  logic [PRESC_WIDTH*CH_NUM-1:0] i_cfg_presc,
  input  logic [CH_NUM-1:0]             i_cfg_cascade,
  input  logic [CH_NUM-1:0]             i_ch_clr,
  input  logic [CH_NUM-1:0]             i_in,
  input  logic [CH_NUM-1:0]             i_keep,
  input  logic [CH_NUM-1:0]             i_up,
  output logic [CH_NUM-1:0]             o_out,
  output logic [CH_NUM-1:0]             o_edge_detect,
  output logic [CH_NUM-1:0]             o_tc,
  output logic [CNT_WIDTH*CH_NUM-1:0]   o_count
);

  // Channel 0 has no upstream stage, so its cascade enable is ignored.
  logic unused_cascade0;
  assign unused_cascade0 = i_cfg_cascade[0];

  for (genvar k = 0; k < int'(CH_NUM); k++) begin : g_ch
    logic casc_en;
    logic casc_tick;

    if (k == 0) begin : g_first
      assign casc_en   = 1'b0;
      assign casc_tick = 1'b0;
    end else begin : g_next
      assign casc_en   = i_cfg_cascade[k];
      assign casc_tick = o_tc[k-1];
    end

    cnt_dly_channel #(
      .CNT_WIDTH   (CNT_WIDTH),
      .PRESC_WIDTH (PRESC_WIDTH)
    ) u_ch (
      .clk          (i_clk),
      .rst          (i_reset),
      .mode         (i_cfg_mode[2*k +: 2]),
      .edge_sel     (i_cfg_edge[2*k +: 2]),
      .data         (i_cfg_data[CNT_WIDTH*k +: CNT_WIDTH]),
      .presc        (i_cfg_presc[PRESC_WIDTH*k +: PRESC_WIDTH]),
      .use_cascade  (casc_en),
      .cascade_tick (casc_tick),
      .clr          (i_ch_clr[k]),
      .din          (i_in[k]),
      .keep         (i_keep[k]),
      .up           (i_up[k]),
      .out          (o_out[k]),
      .edge_det     (o_edge_detect[k]),
      .tc           (o_tc[k]),
      .count        (o_count[CNT_WIDTH*k +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_cnt_dly_array.sv
// Self-checking bench: directed scenarios plus random epochs against a behavioural model.
module tb_cnt_dly_array;

  localparam int CH = 4;
  localparam int CW = 14;
  localparam int PW = 8;
  localparam int M_DLY = 0, M_CNT = 1, M_FSM = 2, M_ONE = 3;
  localparam int E_RISE = 0, E_FALL = 1, E_BOTH = 2, E_NONE = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [2*CH-1:0]   cfg_mode, cfg_edge;
  logic [CW*CH-1:0]  cfg_data;
  logic [PW*CH-1:0]  cfg_presc;
  logic [CH-1:0]     cfg_cascade, ch_clr, din, keep, up;
  logic [CH-1:0]     out, edge_det, tc;
  logic [CW*CH-1:0]  count;

  int total = 0;
  int bad   = 0;

  // Configuration and stimulus as plain integers.
  int c_mode[CH], c_edge[CH], c_data[CH], c_presc[CH];
  bit c_casc[CH], v_clr[CH], v_in[CH], v_keep[CH], v_up[CH];

  // Reference model state.
  int m_cnt[CH], m_pc[CH], m_inq[CH], m_out[CH], m_edg[CH], m_tc[CH], m_wait[CH];

  cnt_dly_array #(.CH_NUM(CH), .CNT_WIDTH(CW), .PRESC_WIDTH(PW)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_cfg_mode    (cfg_mode),
    .i_cfg_edge    (cfg_edge),
    .i_cfg_data    (cfg_data),
    .i_cfg_presc   (cfg_presc),
    .i_cfg_cascade (cfg_cascade),
    .i_ch_clr      (ch_clr),
    .i_in          (din),
    .i_keep        (keep),
    .i_up          (up),
    .o_out         (out),
    .o_edge_detect (edge_det),
    .o_tc          (tc),
    .o_count       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s ch%0d observed=%0d expected=%0d", tag, ch, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < CH; k++) begin
      cfg_mode[2*k +: 2]    = 2'(c_mode[k]);
      cfg_edge[2*k +: 2]    = 2'(c_edge[k]);
      cfg_data[CW*k +: CW]  = CW'(c_data[k]);
      cfg_presc[PW*k +: PW] = PW'(c_presc[k]);
      cfg_cascade[k]        = c_casc[k];
      ch_clr[k]             = v_clr[k];
      din[k]                = v_in[k];
      keep[k]               = v_keep[k];
      up[k]                 = v_up[k];
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_cnt[k] = 0; m_pc[k] = 0; m_inq[k] = 0; m_out[k] = 0;
      m_edg[k] = 0; m_tc[k] = 0; m_wait[k] = 0;
    end
  endtask

  // One clock of behaviour for every channel, from the channel rules.
  task automatic model_step();
    int  tc_old[CH];
    int  prev_in;
    bit  qe, tick, rise, fall;
    for (int k = 0; k < CH; k++) tc_old[k] = m_tc[k];
    for (int k = 0; k < CH; k++) begin
      prev_in = m_inq[k];
      if (v_clr[k]) begin
        m_cnt[k] = 0; m_pc[k] = 0; m_inq[k] = 0; m_out[k] = 0;
        m_edg[k] = 0; m_tc[k] = 0; m_wait[k] = 0;
      end else begin
        rise = (v_in[k] == 1) && (prev_in == 0);
        fall = (v_in[k] == 0) && (prev_in == 1);
        qe   = (c_edge[k] == E_RISE && rise) || (c_edge[k] == E_FALL && fall) ||
               (c_edge[k] == E_BOTH && (rise || fall));
        tick = (k > 0 && c_casc[k]) ? (tc_old[k-1] != 0) : (m_pc[k] == c_presc[k]);
        m_pc[k]  = (m_pc[k] == c_presc[k]) ? 0 : m_pc[k] + 1;
        m_inq[k] = v_in[k];
        m_edg[k] = qe;
        m_tc[k]  = 0;
        if (c_mode[k] == M_DLY) begin
          if (qe) begin m_cnt[k] = c_data[k]; m_wait[k] = 1; end
          else if (m_wait[k] == 0) m_out[k] = prev_in;
          else if (tick) begin
            if (m_cnt[k] == 0) begin m_out[k] = prev_in; m_wait[k] = 0; end
            else m_cnt[k]--;
          end
        end else if (c_mode[k] == M_CNT) begin
          m_out[k] = 0;
          if (qe) m_cnt[k] = c_data[k];
          else if (tick) begin
            if (m_cnt[k] == 0) begin m_cnt[k] = c_data[k]; m_out[k] = 1; m_tc[k] = 1; end
            else m_cnt[k]--;
          end
        end else if (c_mode[k] == M_FSM) begin
          if (qe) m_cnt[k] = 0;
          else if (tick && !v_keep[k]) begin
            if (v_up[k] && m_cnt[k] < c_data[k]) begin
              m_cnt[k]++; m_tc[k] = (m_cnt[k] == c_data[k]);
            end else if (!v_up[k] && m_cnt[k] > 0) begin
              m_cnt[k]--; m_tc[k] = (m_cnt[k] == 0);
            end
          end
          m_out[k] = v_up[k] ? (m_cnt[k] == c_data[k]) : (m_cnt[k] == 0);
        end else begin
          if (m_out[k] == 0) begin
            if (qe) begin m_out[k] = 1; m_cnt[k] = c_data[k]; end
          end else if (tick) begin
            if (m_cnt[k] == 0) begin m_out[k] = 0; m_tc[k] = 1; end
            else m_cnt[k]--;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < CH; k++) begin
      check({tag, "_out"},   k, 32'(out[k]),            32'(m_out[k]));
      check({tag, "_edge"},  k, 32'(edge_det[k]),       32'(m_edg[k]));
      check({tag, "_tc"},    k, 32'(tc[k]),             32'(m_tc[k]));
      check({tag, "_count"}, k, 32'(count[CW*k +: CW]), 32'(m_cnt[k]));
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic set_cfg(input int k, input int md, input int ed, input int da, input int pr, input bit ca);
    c_mode[k] = md; c_edge[k] = ed; c_data[k] = da; c_presc[k] = pr; c_casc[k] = ca;
  endtask

  initial begin
    int tc0[$], tc1[$];
    int r1, f1, e1, h3;

    // Directed configuration for the single-channel scenarios.
    set_cfg(0, M_CNT, E_NONE, 6, 0, 0);
    set_cfg(1, M_DLY, E_RISE, 2, 0, 0);
    set_cfg(2, M_FSM, E_RISE, 5, 0, 0);
    set_cfg(3, M_ONE, E_RISE, 3, 1, 0);
    for (int k = 0; k < CH; k++) begin
      v_clr[k] = 0; v_in[k] = 0; v_keep[k] = 0; v_up[k] = (k == 2);
    end
    rst = 1'b1;
    drive();
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    r1 = 0; f1 = 0; e1 = 0; h3 = 0;
    for (int c = 1; c <= 40; c++) begin
      v_in[1]   = (c >= 3 && c <= 11);
      v_in[3]   = (c >= 6 && c <= 8) || (c >= 10);
      v_in[2]   = (c >= 30);
      v_keep[2] = (c >= 32 && c <= 35);
      drive();
      cycle("dir");
      if (tc[0]) tc0.push_back(c);
      if (edge_det[1]) e1++;
      if (out[1] && r1 == 0) r1 = c;
      if (!out[1] && r1 != 0 && f1 == 0) f1 = c;
      if (out[3]) h3++;
      if (c == 5) begin
        check("fsm_sat_count", 2, 32'(count[2*CW +: CW]), 32'd5);
        check("fsm_sat_out",   2, 32'(out[2]), 32'd1);
      end
      if (c == 35) check("fsm_keep_count", 2, 32'(count[2*CW +: CW]), 32'd1);
    end
    check("cnt_first_tc", 0, 32'(tc0.size() > 0 ? tc0[0] : -1), 32'd1);
    check("cnt_period",   0, 32'(tc0.size() > 1 ? tc0[1] - tc0[0] : -1), 32'd7);
    check("dly_rise_at",  1, 32'(r1), 32'd6);
    check("dly_fall_at",  1, 32'(f1), 32'd13);
    check("dly_edge_cnt", 1, 32'(e1), 32'd1);
    check("oneshot_len",  3, 32'(h3), 32'd8);

    // Cascade: channel 1 ticks on channel 0 terminal pulses.
    set_cfg(0, M_CNT, E_NONE, 1, 0, 0);
    set_cfg(1, M_CNT, E_NONE, 2, 0, 1);
    set_cfg(2, M_DLY, E_NONE, 0, 0, 0);
    set_cfg(3, M_DLY, E_NONE, 0, 0, 0);
    for (int k = 0; k < CH; k++) begin v_clr[k] = 1; v_in[k] = 0; v_keep[k] = 0; end
    drive();
    cycle("clr");
    for (int k = 0; k < CH; k++) v_clr[k] = 0;
    drive();
    for (int c = 1; c <= 40; c++) begin
      cycle("casc");
      if (tc[1]) tc1.push_back(c);
    end
    check("casc_period_a", 1, 32'(tc1.size() > 1 ? tc1[1] - tc1[0] : -1), 32'd6);
    check("casc_period_b", 1, 32'(tc1.size() > 2 ? tc1[2] - tc1[1] : -1), 32'd6);

    // Asynchronous reset in the middle of a one-shot pulse.
    set_cfg(3, M_ONE, E_RISE, 20, 3, 0);
    v_clr[3] = 1;
    drive();
    cycle("clr3");
    v_clr[3] = 0; v_in[3] = 1;
    drive();
    for (int c = 0; c < 5; c++) cycle("os");
    check("os_active", 3, 32'(out[3]), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_mid_out",   3, 32'(out[3]), 32'd0);
    check("rst_mid_count", 3, 32'(count[3*CW +: CW]), 32'd0);
    check_all("rst_mid");
    for (int k = 0; k < CH; k++) v_in[k] = 0;
    drive();
    @(posedge clk);
    #1 rst = 1'b0;

    // Random epochs: fresh configuration, clear all, then random traffic.
    for (int ep = 0; ep < 6; ep++) begin
      for (int k = 0; k < CH; k++) begin
        set_cfg(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 9)),
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        v_clr[k] = 1;
      end
      drive();
      cycle("rclr");
      for (int c = 0; c < 250; c++) begin
        for (int k = 0; k < CH; k++) begin
          v_clr[k] = ($urandom_range(0, 49) == 0);
          if ($urandom_range(0, 4) == 0) v_in[k] = !v_in[k];
          v_keep[k] = ($urandom_range(0, 3) == 0);
          if ($urandom_range(0, 9) == 0) v_up[k] = !v_up[k];
        end
        drive();
        cycle("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnt_dly_array.md
CNT_DLY_ARRAY -- requirements
Module: cnt_dly_array

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of independent counter/delay channels.
REQ-002 SHALL have parameter CNT_WIDTH, default 14, counter and data width per channel.
REQ-003 SHALL have parameter PRESC_WIDTH, default 8, prescaler compare width per channel.
REQ-004 SHALL have port i_clk  input  1  sole clock.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_cfg_mode  input  2*CH_NUM  per-channel mode_t: DLY=0, CNT=1, FSM=2, ONESHOT=3.
REQ-007 SHALL have port i_cfg_edge  input  2*CH_NUM  per-channel edge_t: RISING=0, FALLING=1, BOTH=2, NONE=3.
REQ-008 SHALL have port i_cfg_data  input  CNT_WIDTH*CH_NUM  per-channel counter data.
REQ-009 SHALL have port i_cfg_presc  input  PRESC_WIDTH*CH_NUM  per-channel tick divider; a tick occurs every (presc+1) clocks.
REQ-010 SHALL have port i_cfg_cascade  input  CH_NUM  when set, channel k ticks on channel k-1 terminal pulse; bit 0 is ignored.
REQ-011 SHALL have port i_ch_clr  input  CH_NUM  synchronous per-channel clear.
REQ-012 SHALL have ports i_in, i_keep, i_up  input  CH_NUM each  per-channel input, FSM hold, and FSM direction.
REQ-013 SHALL have ports o_out, o_edge_detect, o_tc  output  CH_NUM each  per-channel output, qualified-edge pulse, and terminal pulse.
REQ-014 SHALL have port o_count  output  CNT_WIDTH*CH_NUM  per-channel live counter value.

Function
REQ-015 Qualified edge: at a clock where i_in differs from registered in_q and edge_t matches. NONE never qualifies. in_q samples i_in every clock.
REQ-016 o_edge_detect SHALL be a registered one-clock pulse, high in the cycle after the qualified-edge clock.
REQ-017 The prescaler SHALL count 0..presc and then wrap; the tick is asserted on wrap. presc=0 gives a tick every clock.
REQ-018 Cascaded tick SHALL equal registered o_tc of channel k-1, so each cascade stage adds one clock of latency.
REQ-019 DLY: a qualified edge loads counter=data; each tick decrements; a tick at 0 sets o_out<=in_q. o_out therefore follows a delayed edge data+1 ticks later.
REQ-020 DLY: a new qualified edge while waiting SHALL reload the counter (restart). Non-qualified transitions SHALL reach o_out on the next clock.
REQ-021 CNT: the counter decrements per tick. A tick at 0 reloads data and pulses o_out and o_tc for one clock, giving a period of (data+1) ticks.
REQ-022 CNT: a qualified edge SHALL reload data. An edge in the same cycle as a tick at 0 reloads with no pulse.
REQ-023 FSM: a tick with i_keep=0 SHALL step the counter up if i_up=1 and down otherwise, saturating at data and at 0. i_keep=1 holds the counter.
REQ-024 FSM: o_out = (count==data) when i_up=1, else (count==0). o_tc pulses on the step that reaches the limit. A qualified edge clears count to 0, with priority over the tick.
REQ-025 ONESHOT: a qualified edge while idle sets o_out=1 and counter=data; each tick decrements; a tick at 0 clears o_out and pulses o_tc. Edges during the pulse SHALL be ignored.
REQ-026 i_ch_clr SHALL return a channel to its reset state on the next clock, with priority over all events.
REQ-027 Configuration changes SHALL take effect at the next load or reload. A mode change without i_ch_clr is undefined.
REQ-028 Counters SHALL never wrap; all arithmetic stays within CNT_WIDTH.

Reset
REQ-029 While i_reset is high, every output, counter, prescaler, in_q and tc register SHALL be 0, cleared asynchronously.
REQ-030 After reset in CNT mode, the first tick SHALL see count 0 and emit an o_tc pulse, then reload data.

Structure
REQ-031 Package cnt_dly_array_pkg SHALL hold mode_t, edge_t and the default parameter constants.
REQ-032 Per-channel logic SHALL live in sub-module cnt_dly_channel, instantiated CH_NUM times by generate, with the cascade tick wired between instances.

Verification
REQ-033 CNT, ch0 data=6, presc=0: o_tc pulses one clock after reset release, then every 7 clocks.
REQ-034 DLY, ch1 data=2, RISING: i_in rises, so o_out rises 3 clocks after the first clock sampling i_in=1. The fall appears after 1 clock. o_edge_detect pulses once.
REQ-035 FSM, ch2 data=5, up=1, keep=0: count goes 0..5 and saturates, o_out is high from count 5. A rising i_in clears to 0. keep=1 freezes count.
REQ-036 ONESHOT, ch3 data=3, presc=1: o_out is high for 8 clocks. A second edge mid-pulse does not extend it.
REQ-037 Cascade: ch0 CNT data=1, presc=0; ch1 CNT data=2, cascade=1. Then ch1 o_tc period is 6 clocks.
REQ-038 Reset: assert i_reset mid ONESHOT pulse, so o_out and o_count drop to 0 without a clock edge.
